fir_stream_param: RTL and testbench

//  Parametrised, runtime-programmable direct-form FIR filter on AXI-Stream in/out.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_round_sat.sv | 41 ++++
 rtl/fir_stream_param.sv | 147 ++++++++++++++
 tb/tb_fir_stream_param.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, types and width helpers for the streaming FIR filter.
package fir_pkg;

    localparam int unsigned TapIdxW = 6;

    // Sideband that rides alongside each sample through the pipeline.
    typedef struct packed {
        logic [3:0] keep;
        logic       last;
    } side_t;

    function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation of the accumulator.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W     = 36,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    // One extra bit above ACC_W keeps the rounding add from wrapping.
    localparam int W = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;
    localparam logic [W-1:0] One = W'(1);
    localparam logic signed [W-1:0] Bias = (One << OUT_SHIFT) >> 1;
    localparam logic signed [W-1:0] MaxV = (One << (OUT_W - 1)) - One;
    localparam logic signed [W-1:0] MinV = ~MaxV;

    logic signed [W-1:0] sum;
    logic signed [W-1:0] shifted;
    logic                over_hi;
    logic                over_lo;

    always_comb begin
        sum     = {{(W - ACC_W){acc_i[ACC_W-1]}}, acc_i} + Bias;
        shifted = sum >>> OUT_SHIFT;
        over_hi = shifted > MaxV;
        over_lo = shifted < MinV;
        sat_o   = over_hi | over_lo;
        if (over_hi) begin
            data_o = MaxV[OUT_W-1:0];
        end else if (over_lo) begin
            data_o = MinV[OUT_W-1:0];
        end else begin
            data_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fir_stream_param.sv
// Runtime-programmable direct-form FIR on AXI-Stream: delay line, registered products,
// registered sum with rounding/saturation; full backpressure with tkeep/tlast sideband.
module fir_stream_param
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 15,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 0,
    parameter int ACC_W     = acc_width(DATA_W, COEF_W, NTAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] s_axis_tdata,
    input  logic [3:0]               s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic signed [OUT_W-1:0]  m_axis_tdata,
    output logic [3:0]               m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic                     coef_wr_en,
    input  logic [TapIdxW-1:0]       coef_wr_addr,
    input  logic signed [COEF_W-1:0] coef_wr_data,
    output logic                     sat_sticky
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic stall;
    logic accept;

    logic signed [DATA_W-1:0] x_q    [NTAPS];
    logic signed [COEF_W-1:0] c_q    [NTAPS];
    logic signed [PROD_W-1:0] prod_q [NTAPS];
    logic                     v0_q, v1_q, v2_q;
    side_t                    side0_q, side1_q, side2_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  rs_data;
    logic                     rs_sat;
    logic signed [OUT_W-1:0]  data_q;
    logic                     user_q;
    logic                     sticky_q;

    assign stall         = v2_q & ~m_axis_tready;
    assign s_axis_tready = ~stall & ~reset;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Out-of-range addresses match no tap and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) c_q[i] <= '0;
        end else if (coef_wr_en) begin
            for (int i = 0; i < NTAPS; i++) begin
                if (coef_wr_addr == TapIdxW'(i)) c_q[i] <= coef_wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
            v0_q    <= 1'b0;
            side0_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
            v0_q <= 1'b0;
        end else if (!stall) begin
            v0_q <= accept;
            if (accept) begin
                x_q[0] <= s_axis_tdata;
                for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
                side0_q <= {s_axis_tkeep, s_axis_tlast};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) prod_q[i] <= '0;
            v1_q    <= 1'b0;
            side1_q <= '0;
        end else if (clear) begin
            v1_q <= 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < NTAPS; i++) begin
                prod_q[i] <= PROD_W'(c_q[i]) * PROD_W'(x_q[i]);
            end
            v1_q    <= v0_q;
            side1_q <= side0_q;
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NTAPS; i++) acc = acc + ACC_W'(prod_q[i]);
    end

    fir_round_sat #(
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_round_sat (
        .acc_i (acc),
        .data_o(rs_data),
        .sat_o (rs_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_q    <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            side2_q <= '0;
        end else if (clear) begin
            v2_q <= 1'b0;
        end else if (!stall) begin
            v2_q    <= v1_q;
            data_q  <= rs_data;
            user_q  <= rs_sat;
            side2_q <= side1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (clear) begin
            sticky_q <= 1'b0;
        end else if (v2_q && m_axis_tready && user_q) begin
            sticky_q <= 1'b1;
        end
    end

    assign m_axis_tvalid = v2_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tkeep  = side2_q.keep;
    assign m_axis_tlast  = side2_q.last;
    assign sat_sticky    = sticky_q;

endmodule

// File: tb/tb_fir_stream_param.sv
// Scoreboard bench: instance A (15 taps, 32-bit out) and instance B (4 taps, 16-bit out, shift 2).
module tb_fir_stream_param;

    typedef struct {
        longint     data;
        bit         user;
        logic [3:0] keep;
        bit         last;
        int         issue_cyc;
        bit         chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   a_outs = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    logic               a_clear, b_clear;
    logic signed [15:0] a_sdata, b_sdata;
    logic [3:0]         a_skeep, b_skeep;
    logic               a_slast, b_slast, a_svalid, b_svalid, a_sready, b_sready;
    logic signed [31:0] a_mdata;
    logic signed [15:0] b_mdata;
    logic [3:0]         a_mkeep, b_mkeep;
    logic               a_mlast, b_mlast, a_muser, b_muser, a_mvalid, b_mvalid;
    logic               a_mready = 1'b1;
    logic               b_mready = 1'b1;
    logic               a_cwe, b_cwe;
    logic [5:0]         a_cwa, b_cwa;
    logic signed [15:0] a_cwd, b_cwd;
    logic               a_sticky, b_sticky;
    bit                 bp_en = 1'b0;
    int                 bp_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_stream_param #(
        .DATA_W(16), .COEF_W(16), .NTAPS(15), .OUT_W(32), .OUT_SHIFT(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .clear(a_clear),
        .s_axis_tdata(a_sdata), .s_axis_tkeep(a_skeep), .s_axis_tlast(a_slast),
        .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready),
        .m_axis_tdata(a_mdata), .m_axis_tkeep(a_mkeep), .m_axis_tlast(a_mlast),
        .m_axis_tuser(a_muser), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
        .coef_wr_en(a_cwe), .coef_wr_addr(a_cwa), .coef_wr_data(a_cwd),
        .sat_sticky(a_sticky)
    );

    fir_stream_param #(
        .DATA_W(16), .COEF_W(16), .NTAPS(4), .OUT_W(16), .OUT_SHIFT(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .clear(b_clear),
        .s_axis_tdata(b_sdata), .s_axis_tkeep(b_skeep), .s_axis_tlast(b_slast),
        .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
        .m_axis_tdata(b_mdata), .m_axis_tkeep(b_mkeep), .m_axis_tlast(b_mlast),
        .m_axis_tuser(b_muser), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
        .coef_wr_en(b_cwe), .coef_wr_addr(b_cwa), .coef_wr_data(b_cwd),
        .sat_sticky(b_sticky)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output ready toggles every 3 cycles while backpressure is enabled.
    always begin
        @(posedge clk);
        #1;
        if (bp_en) begin
            bp_cnt++;
            if (bp_cnt == 3) begin
                bp_cnt   = 0;
                a_mready = ~a_mready;
            end
        end else begin
            bp_cnt   = 0;
            a_mready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset && a_mvalid && a_mready) begin
            chk("a_expected_output", longint'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_data", longint'(a_mdata), ea.data);
                chk("a_user", longint'(a_muser), longint'(ea.user));
                chk("a_keep", longint'(a_mkeep), longint'(ea.keep));
                chk("a_last", longint'(a_mlast), longint'(ea.last));
                if (ea.chk_lat) chk("a_latency", longint'(cyc - ea.issue_cyc), 2);
            end
            a_outs++;
        end
    end

    always @(negedge clk) begin
        if (!reset && b_mvalid && b_mready) begin
            chk("b_expected_output", longint'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_data", longint'(b_mdata), eb.data);
                chk("b_user", longint'(b_muser), longint'(eb.user));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit inst, input longint x, input logic [3:0] k, input bit l,
                        input bit push, input longint ey, input bit eu, input bit lat);
        int   n;
        logic rdy;
        exp_t e;
        if (inst) begin
            b_sdata = 16'(x); b_skeep = k; b_slast = l; b_svalid = 1'b1;
        end else begin
            a_sdata = 16'(x); a_skeep = k; a_slast = l; a_svalid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = inst ? b_sready : a_sready;
        end while (!rdy && n < 200);
        if (!rdy) chk("s_tready_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_svalid = 1'b0;
        b_svalid = 1'b0;
        if (push) begin
            e.data = ey; e.user = eu; e.keep = k; e.last = l;
            e.issue_cyc = cyc; e.chk_lat = lat;
            if (inst) qb.push_back(e);
            else qa.push_back(e);
        end
    endtask

    task automatic wr_coef(input bit inst, input logic [5:0] addr, input longint val);
        if (inst) begin
            b_cwe = 1'b1; b_cwa = addr; b_cwd = 16'(val);
        end else begin
            a_cwe = 1'b1; a_cwa = addr; a_cwd = 16'(val);
        end
        @(posedge clk);
        #1;
        a_cwe = 1'b0;
        b_cwe = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_a", longint'(qa.size()), 0);
        chk("drain_b", longint'(qb.size()), 0);
    endtask

    initial begin
        int c0;
        int outs0;
        reset = 1'b1;
        a_clear = 0; b_clear = 0;
        a_sdata = 0; a_skeep = 0; a_slast = 0; a_svalid = 0;
        b_sdata = 0; b_skeep = 0; b_slast = 0; b_svalid = 0;
        a_cwe = 0; a_cwa = 0; a_cwd = 0; b_cwe = 0; b_cwa = 0; b_cwd = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", longint'(a_mvalid), 0);
        chk("rst_m_tdata", longint'(a_mdata), 0);
        chk("rst_m_tkeep", longint'(a_mkeep), 0);
        chk("rst_m_tlast", longint'(a_mlast), 0);
        chk("rst_m_tuser", longint'(a_muser), 0);
        chk("rst_sat_sticky", longint'(a_sticky), 0);
        chk("rst_s_tready_a", longint'(a_sready), 0);
        chk("rst_s_tready_b", longint'(b_sready), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Impulse: c[i] = i+1 gives 1..15 then 0, back to back.
        for (int i = 0; i < 15; i++) wr_coef(0, 6'(i), i + 1);
        c0 = cyc;
        send(0, 1, 4'hF, 0, 1, 1, 0, 1);
        for (int j = 1; j <= 15; j++) send(0, 0, 4'hF, 0, 1, (j < 15) ? j + 1 : 0, 0, 0);
        chk("a_throughput_cycles", longint'(cyc - c0), 16);
        drain();

        // Backpressure with y[n] = x[n] + 2*x[n-1], x[n] = n+1 -> 3n+1; tlast/tkeep on sample 7.
        wr_coef(0, 0, 1);
        wr_coef(0, 1, 2);
        for (int i = 2; i < 15; i++) wr_coef(0, 6'(i), 0);
        bp_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            send(0, n + 1, (n == 7) ? 4'h3 : 4'hF, n == 7, 1, 3 * n + 1, 0, 0);
        end
        drain();
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("a_sticky_no_sat", longint'(a_sticky), 0);

        // Clear with two samples in flight; out-of-range coefficient writes must not land.
        outs0 = a_outs;
        send(0, 50, 4'hF, 0, 0, 0, 0, 0);
        send(0, 60, 4'hF, 0, 0, 0, 0, 0);
        a_clear = 1'b1;
        @(posedge clk);
        #1;
        a_clear = 1'b0;
        wr_coef(0, 15, 100);
        wr_coef(0, 16, 100);
        wr_coef(0, 63, 100);
        repeat (5) @(posedge clk);
        #1;
        chk("a_clear_no_outputs", longint'(a_outs - outs0), 0);
        send(0, 1, 4'hF, 0, 1, 1, 0, 0);
        send(0, 0, 4'hF, 0, 1, 2, 0, 0);
        drain();

        // Rounding on B: (6+2)>>>2 = 2, (-6+2)>>>2 = -1.
        wr_coef(1, 0, 1);
        send(1, 6, 4'hF, 0, 1, 2, 0, 0);
        send(1, -6, 4'hF, 0, 1, -1, 0, 0);
        drain();
        chk("b_sticky_no_sat", longint'(b_sticky), 0);

        // Saturation on B in both directions.
        wr_coef(1, 0, 32767);
        send(1, 32767, 4'hF, 0, 1, 32767, 1, 0);
        send(1, -32768, 4'hF, 0, 1, -32768, 1, 0);
        drain();
        chk("b_sticky_set", longint'(b_sticky), 1);
        b_clear = 1'b1;
        @(posedge clk);
        #1;
        b_clear = 1'b0;
        chk("b_sticky_cleared", longint'(b_sticky), 0);

        // Reset mid-stream on A: in-flight samples vanish, coefficients return to zero.
        send(0, 5, 4'hF, 0, 0, 0, 0, 0);
        send(0, 6, 4'hF, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("midrst_m_tvalid", longint'(a_mvalid), 0);
        chk("midrst_s_tready", longint'(a_sready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(0, 7, 4'hF, 0, 1, 0, 0, 0);
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("end_queue_a", longint'(qa.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
